unified_mem_arbiter: RTL and testbench

- Shares one single-ported synchronous unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences each access through a fixed-latency FSM.
- Returns registered read data with a one-cycle valid pulse.
- Drives per-requester stall outputs, which the pipeline ORs into its PCWrite/IF_ID_Write and pipeline-register hold logic.
- Data accesses have priority; a starvation counter guarantees fetch progress.

---
 rtl/unified_mem_arbiter_pkg.sv | 16 +
 rtl/unified_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM unified memory arbiter.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Purpose: shares one single-ported synchronous memory between fetch and load/store, data first.
// Latency: grant edge -> mem_en next cycle -> valid pulse MEM_LAT+2 cycles after the request.
// Backpressure: requesters hold req until their valid pulse; stall = req & ~valid.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t           state;
    state_t           state_nxt;
    logic             owner;
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_d;
    logic             grant_if;
    logic             unused_addr_lsb;

    // Byte offsets never reach the word-addressed memory.
    assign unused_addr_lsb = ^{if_addr[1:0], d_addr[1:0]};

    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;
    assign busy     = (state != IDLE);

    always_comb begin
        grant_d   = 1'b0;
        grant_if  = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                // Data wins unless fetch has been passed over STARVE_MAX times in a row.
                grant_d  = d_req && (!if_req || starve_cnt != CNT_W'(STARVE_MAX));
                grant_if = if_req && !grant_d;
                if (grant_d || grant_if) state_nxt = ISSUE;
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (lat_cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= OWN_IF;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner     <= OWN_D;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr[ADDR_W-1:2];
                        mem_wdata <= d_wdata;
                        if (!if_req)
                            starve_cnt <= '0;
                        else if (starve_cnt != CNT_W'(STARVE_MAX))
                            starve_cnt <= starve_cnt + CNT_W'(1);
                    end else if (grant_if) begin
                        owner      <= OWN_IF;
                        mem_en     <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr[ADDR_W-1:2];
                        starve_cnt <= '0;
                    end
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    lat_cnt <= CNT_W'(MEM_LAT);
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - CNT_W'(1);
                    if (lat_cnt == CNT_W'(1)) begin
                        if (owner == OWN_D) begin
                            d_rdata <= mem_rdata;
                            d_valid <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: inputs change on the falling edge, outputs sampled 1ns later.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({mem_en, mem_we, if_valid, d_valid, busy, if_stall, d_stall} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b required 0000000",
                {mem_en, mem_we, if_valid, d_valid, busy, if_stall, d_stall});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_data got %h %h %h %h required all zero",
                mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fetch();
        mem_rdata = 32'h2008_0005;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 0) begin if_req = 1'b1; if_addr = 32'h0000_0010; end
            if (c == 5) if_req = 1'b0;
            #1;
            n_cmp++;
            if (mem_en !== (c == 1) || mem_we !== 1'b0) begin
                n_fail++; $display("FAIL fetch_en c=%0d got en=%b we=%b required en=%b we=0",
                    c, mem_en, mem_we, (c == 1));
            end
            n_cmp++;
            if (if_valid !== (c == 4) || d_valid !== 1'b0) begin
                n_fail++; $display("FAIL fetch_valid c=%0d got if=%b d=%b required if=%b d=0",
                    c, if_valid, d_valid, (c == 4));
            end
            n_cmp++;
            if (if_stall !== (c <= 3)) begin
                n_fail++; $display("FAIL fetch_stall c=%0d got %b required %b", c, if_stall, (c <= 3));
            end
            if (c == 1) begin
                n_cmp++;
                if (mem_addr !== 30'h4) begin
                    n_fail++; $display("FAIL fetch_addr got %h required 4", mem_addr);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (if_rdata !== 32'h2008_0005) begin
                    n_fail++; $display("FAIL fetch_rdata got %h required 20080005", if_rdata);
                end
            end
        end
    endtask

    task automatic test_store();
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0103; d_wdata = 32'hDEAD_BEEF;
            end
            if (c == 5) begin d_req = 1'b0; d_we = 1'b0; end
            #1;
            n_cmp++;
            if (mem_en !== (c == 1) || mem_we !== (c == 1)) begin
                n_fail++; $display("FAIL store_en c=%0d got en=%b we=%b required %b", c, mem_en, mem_we, (c == 1));
            end
            n_cmp++;
            if (d_valid !== (c == 4) || if_valid !== 1'b0) begin
                n_fail++; $display("FAIL store_valid c=%0d got d=%b if=%b required d=%b if=0",
                    c, d_valid, if_valid, (c == 4));
            end
            n_cmp++;
            if (d_stall !== (c <= 3)) begin
                n_fail++; $display("FAIL store_stall c=%0d got %b required %b", c, d_stall, (c <= 3));
            end
            if (c >= 1 && c <= 3) begin
                n_cmp++;
                if (mem_addr !== 30'h40 || mem_wdata !== 32'hDEAD_BEEF) begin
                    n_fail++; $display("FAIL store_addr c=%0d got %h/%h required 40/deadbeef",
                        c, mem_addr, mem_wdata);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        mem_rdata = 32'h1111_1111;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c == 0) begin d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0020; end
            if (c == 5) d_addr = 32'h0000_0300;
            if (c == 10) d_req = 1'b0;
            #1;
            n_cmp++;
            if (mem_en !== (c == 1 || c == 6)) begin
                n_fail++; $display("FAIL b2b_en c=%0d got %b required %b", c, mem_en, (c == 1 || c == 6));
            end
            n_cmp++;
            if (d_valid !== (c == 4 || c == 9)) begin
                n_fail++; $display("FAIL b2b_valid c=%0d got %b required %b", c, d_valid, (c == 4 || c == 9));
            end
            if (c == 6) begin
                n_cmp++;
                if (mem_addr !== 30'hC0) begin
                    n_fail++; $display("FAIL b2b_addr got %h required c0", mem_addr);
                end
            end
        end
    endtask

    task automatic test_starvation();
        int k;
        logic exp_d;
        logic exp_en;
        mem_rdata = 32'h0BAD_F00D;
        for (int c = 0; c <= 50; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if_req = 1'b1; if_addr = 32'h0000_0100;
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
            end
            if (c == 50) begin if_req = 1'b0; d_req = 1'b0; end
            #1;
            exp_en = (c >= 1 && c <= 46 && (c - 1) % 5 == 0);
            n_cmp++;
            if (mem_en !== exp_en) begin
                n_fail++; $display("FAIL starve_en c=%0d got %b required %b", c, mem_en, exp_en);
            end
            if (exp_en) begin
                k = (c - 1) / 5;
                exp_d = (k % 5 != 4);
                n_cmp++;
                if (mem_addr !== (exp_d ? 30'h80 : 30'h40)) begin
                    n_fail++; $display("FAIL starve_order grant=%0d got addr %h required %h",
                        k, mem_addr, (exp_d ? 30'h80 : 30'h40));
                end
            end
            if (c >= 4 && c <= 49 && (c - 4) % 5 == 0) begin
                k = (c - 4) / 5;
                exp_d = (k % 5 != 4);
                n_cmp++;
                if (d_valid !== exp_d || if_valid !== !exp_d || mem_en !== 1'b0) begin
                    n_fail++; $display("FAIL starve_valid c=%0d got d=%b if=%b en=%b required d=%b if=%b en=0",
                        c, d_valid, if_valid, mem_en, exp_d, !exp_d);
                end
            end
        end
    endtask

    task automatic test_withdraw();
        mem_rdata = 32'h55AA_55AA;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
                if_req = 1'b1; if_addr = 32'h0000_0080;
            end
            if (c == 2) d_req = 1'b0;
            if (c == 10) if_req = 1'b0;
            #1;
            n_cmp++;
            if (d_valid !== (c == 4)) begin
                n_fail++; $display("FAIL wd_dvalid c=%0d got %b required %b", c, d_valid, (c == 4));
            end
            if (c >= 2) begin
                n_cmp++;
                if (d_stall !== 1'b0) begin
                    n_fail++; $display("FAIL wd_dstall c=%0d got %b required 0", c, d_stall);
                end
            end
            n_cmp++;
            if (mem_en !== (c == 1 || c == 6)) begin
                n_fail++; $display("FAIL wd_en c=%0d got %b required %b", c, mem_en, (c == 1 || c == 6));
            end
            if (c == 4) begin
                n_cmp++;
                if (d_rdata !== 32'h55AA_55AA) begin
                    n_fail++; $display("FAIL wd_drdata got %h required 55aa55aa", d_rdata);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (mem_addr !== 30'h20) begin
                    n_fail++; $display("FAIL wd_ifaddr got %h required 20", mem_addr);
                end
            end
            n_cmp++;
            if (if_valid !== (c == 9)) begin
                n_fail++; $display("FAIL wd_ifvalid c=%0d got %b required %b", c, if_valid, (c == 9));
            end
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            if (c == 0) begin
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0008;
                if_req = 1'b1; if_addr = 32'h0000_0004;
            end
        end
        #1;
        n_cmp++;
        if (dut.starve_cnt !== 4'd1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL arst_pre got starve=%0d busy=%b required 1/1", dut.starve_cnt, busy);
        end
        d_req = 1'b0; if_req = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({mem_en, mem_we, if_valid, d_valid, busy, if_stall, d_stall} !== 7'b0 ||
            {mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
            n_fail++; $display("FAIL arst_now got ctrl=%b addr=%h required all zero",
                {mem_en, mem_we, if_valid, d_valid, busy, if_stall, d_stall}, mem_addr);
        end
        n_cmp++;
        if (dut.starve_cnt !== 4'd0) begin
            n_fail++; $display("FAIL arst_starve got %0d required 0", dut.starve_cnt);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({mem_en, if_valid, d_valid, busy} !== 4'b0) begin
                n_fail++; $display("FAIL arst_after c=%0d got en/ifv/dv/busy=%b required 0000",
                    c, {mem_en, if_valid, d_valid, busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_starvation();
        test_withdraw();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
